// File: rtl/click_pkg.sv
// Shared types and defaults for the clocked-to-click bridge.
// Used by sync_to_click_tx (optional HS_TIMEOUT_EN handshake watchdog).
package click_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK,
    WAIT_NACK
  } tx_state_t;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop level synchroniser with asynchronous active-low clear.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/sync_to_click_tx.sv
// Valid/ready FIFO feeding a 4-phase bundled-data producer for a click pipeline.
// Define HS_TIMEOUT_EN to add the TIMEOUT_CYC parameter and sticky hs_timeout output.
module sync_to_click_tx
  import click_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
`ifdef HS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       Rreq,
  input  logic                       Rack,
  output logic [DATA_W-1:0]          Rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef HS_TIMEOUT_EN
  , output logic                     hs_timeout
`endif
);

  // Upstream: a word moves when in_valid && in_ready at a rising edge.
  // Downstream: Rreq/Rack run return-to-zero; Rdata only changes between transactions.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              push;
  logic              pop;
  logic              avail_q;
  logic              ack_meta;
  logic              ack_s;
  tx_state_t         state;

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Rack),
    .q     (ack_meta)
  );

  // Extra retiming flop: Rreq reacts SYNC_STAGES+1 edges after Rack is first sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s <= 1'b0;
    end else begin
      ack_s <= ack_meta;
    end
  end

  assign push = in_valid && in_ready;

  // From IDLE a new word is only visible a cycle after its push edge (avail_q).
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:      pop = avail_q && (count != '0);
      WAIT_NACK: pop = !ack_s && (count != '0);
      default:   pop = 1'b0;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_nxt;
      in_ready <= (count_nxt < DEPTH_C);
      avail_q  <= (count != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Rreq  <= 1'b0;
      Rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          Rreq  <= 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_s) begin
            Rreq  <= 1'b0;
            state <= WAIT_NACK;
          end
        end
        WAIT_NACK: begin
          if (!ack_s) begin
            state <= pop ? SETUP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        Rdata <= mem[rd_ptr];
      end
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt;
  logic          waiting;
  logic          leaving;

  assign waiting = (state == WAIT_ACK) || (state == WAIT_NACK);
  assign leaving = (state == WAIT_ACK) ? ack_s : !ack_s;

  // Counter stalls once the flag is set; the handshake itself keeps waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      hs_timeout <= 1'b0;
    end else if (!waiting || leaving) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      hs_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_to_click_tx.sv
// Bench for sync_to_click_tx: directed latency/full/reset sequences plus random traffic.
`timescale 1ns/1ps
module tb_sync_to_click_tx;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              Rack = 1'b0;
  logic              in_ready;
  logic              Rreq;
  logic [DATA_W-1:0] Rdata;
  logic [CW-1:0]     count;
`ifdef HS_TIMEOUT_EN
  logic              hs_timeout;
`endif

  sync_to_click_tx #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
`ifdef HS_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .Rreq     (Rreq),
    .Rack     (Rack),
    .Rdata    (Rdata),
    .count    (count)
`ifdef HS_TIMEOUT_EN
    , .hs_timeout (hs_timeout)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- click-side responder ----------------
  logic resp_en = 1'b0;
  logic rand_dly = 1'b0;
  int   ack_dly = 1;
  int   resp_wait = 0;
  int   rack_fall_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n || !resp_en) begin
        resp_wait = 0;
        if (!rst_n) Rack = 1'b0;
      end else if (Rreq != Rack) begin
        if (resp_wait >= ack_dly) begin
          Rack = Rreq;
          resp_wait = 0;
          if (!Rack) rack_fall_cyc = cyc;
          if (rand_dly) ack_dly = $urandom_range(0, 4);
        end else begin
          resp_wait++;
        end
      end else begin
        resp_wait = 0;
      end
    end
  end

  // ---------------- monitor: order, stability, occupancy rules ----------------
  logic              prev_rreq = 1'b0;
  logic              in_txn = 1'b0;
  logic              chk_gap = 1'b0;
  logic [DATA_W-1:0] txn_data = '0;
  int                rises = 0;
  int                rst_age = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rreq = 1'b0;
      in_txn    = 1'b0;
      rst_age   = 0;
    end else begin
      rst_age++;
      if (Rreq && !prev_rreq) begin
        rises++;
        check("txn_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("txn_data_order", Rdata, exp_q.pop_front());
        if (chk_gap) check("b2b_rack_fall_to_rreq", cyc - rack_fall_cyc, SYNC_STAGES + 3);
        in_txn   = 1'b1;
        txn_data = Rdata;
      end else if (in_txn) begin
        if (Rreq || Rack) check("rdata_stable", Rdata, txn_data);
        else in_txn = 1'b0;
      end
      if (rst_age >= 2) begin
        check("in_ready_rule", in_ready, 32'(count < DEPTH));
        check("count_bound", 32'(count <= DEPTH), 1);
      end
      prev_rreq = Rreq;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_rreq", Rreq, 0);
    check("rst_rdata", Rdata, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_first_edge", in_ready, 1);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, output logic ok);
    int n = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      n++;
    end
    if (ok) exp_q.push_back(d);
    check("push_accepted", ok, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_rise(input string name);
    int n = 0;
    while (!Rreq && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rreq_rise"}, Rreq, 1);
  endtask

  task automatic drain(input string name, input int budget);
    int  n = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !Rreq && !Rack;
    end
    check({name, "_drained"}, done, 1);
    repeat (SYNC_STAGES + 3) @(negedge clk);
    check({name, "_idle_rreq"}, Rreq, 0);
    check({name, "_idle_count"}, count, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              exp_acc;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_vecs(input int first, input int last);
    logic acc;
    @(posedge clk);
    #1;
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      @(negedge clk);
      acc = in_ready;
      check($sformatf("accept_vec%0d", i), acc, vecs[i].exp_acc);
      @(posedge clk);
      if (acc) exp_q.push_back(vecs[i].data);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic ok;
    logic acc;
    int   r0;
    int   n_acc;

    for (int i = 0; i < 4; i++) vecs[i] = '{data: 8'(i + 1), exp_acc: 1'b1};
    for (int i = 0; i < 6; i++) vecs[4 + i] = '{data: 8'(8'h10 + i), exp_acc: (i < 5)};

    do_reset();

    // Single word: exact push-to-Rdata/Rreq latency and ack response.
    r0 = rises;
    push_word(8'h5A, ok);
    @(negedge clk); check("single_count_after_push", count, 1);
    @(negedge clk); check("single_rdata_n1", Rdata, 0);
                    check("single_rreq_n1", Rreq, 0);
    @(negedge clk); check("single_rdata_n2", Rdata, 8'h5A);
                    check("single_count_n2", count, 0);
                    check("single_rreq_n2", Rreq, 0);
    @(negedge clk); check("single_rreq_n3", Rreq, 1);
    repeat (2) @(posedge clk);
    #1 Rack = 1'b1;
    @(posedge clk);
    for (int i = 0; i < SYNC_STAGES + 1; i++) begin
      @(negedge clk);
      check($sformatf("single_rreq_held_k%0d", i), Rreq, 1);
    end
    @(negedge clk); check("single_rreq_fall_k3", Rreq, 0);
    Rack = 1'b0;
    repeat (6) @(negedge clk);
    check("single_one_txn", rises - r0, 1);
    check("single_rreq_idle", Rreq, 0);
    check("single_q_empty", exp_q.size(), 0);

    // Rack glitch while idle must not start anything.
    r0 = rises;
    @(posedge clk); #1 Rack = 1'b1;
    @(posedge clk); #1 Rack = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_no_txn", rises - r0, 0);
    check("glitch_rreq", Rreq, 0);

    // Back-to-back: 0x01..0x04, no IDLE between transactions.
    r0 = rises;
    resp_en = 1'b1;
    ack_dly = 1;
    apply_vecs(0, 3);
    wait_rise("b2b_first");
    @(posedge clk);
    chk_gap = 1'b1;
    drain("b2b", 200);
    chk_gap = 1'b0;
    check("b2b_txn_count", rises - r0, 4);

    // Full: Rack held low, 0x15 must be refused.
    r0 = rises;
    resp_en = 1'b0;
    apply_vecs(4, 9);
    @(negedge clk);
    check("full_count", count, DEPTH);
    check("full_in_ready", in_ready, 0);
    check("full_rreq_inflight", Rreq, 1);
    check("full_rdata_inflight", Rdata, 8'h10);
    repeat (5) @(negedge clk);
    check("full_still_full", count, DEPTH);
    resp_en = 1'b1;
    drain("full", 300);
    check("full_txn_count", rises - r0, 5);

    // Mid-transaction asynchronous reset.
    resp_en = 1'b0;
    push_word(8'h77, ok);
    wait_rise("midrst");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rreq_now", Rreq, 0);
    check("midrst_count_now", count, 0);
    check("midrst_rdata_now", Rdata, 0);
    check("midrst_in_ready_now", in_ready, 0);
    exp_q.delete();
    do_reset();
    r0 = rises;
    resp_en = 1'b1;
    push_word(8'hA5, ok);
    drain("after_rst", 200);
    check("after_rst_txn_count", rises - r0, 1);

    // Random traffic with random click-side delays.
    r0 = rises;
    n_acc = 0;
    rand_dly = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(in_data);
        n_acc++;
      end
      #1;
    end
    in_valid = 1'b0;
    drain("random", 600);
    check("random_txn_count", rises - r0, n_acc);
    rand_dly = 1'b0;
    ack_dly  = 1;

`ifdef HS_TIMEOUT_EN
    // Handshake watchdog: never acknowledge.
    resp_en = 1'b0;
    do_reset();
    push_word(8'h3C, ok);
    wait_rise("tmo");
    repeat (15) @(negedge clk);
    check("tmo_not_yet", hs_timeout, 0);
    @(negedge clk);
    check("tmo_set", hs_timeout, 1);
    check("tmo_rreq_held", Rreq, 1);
    repeat (10) @(negedge clk);
    check("tmo_sticky", hs_timeout, 1);
    exp_q.delete();
    do_reset();
    check("tmo_cleared", hs_timeout, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
